// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and helpers.
// Imported by the TX engine today and by the RX engine later.
// No ports; compile before any file that imports it.
package uart_pkg;

  // Frame sequencer states. PARITY is only reachable when parity support is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ALIGN  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

  localparam logic        UART_IDLE_LEVEL  = 1'b1;
  localparam logic        UART_START_LEVEL = 1'b0;
  localparam int unsigned DEFAULT_DIVISOR  = 5208;

  // Mask that keeps the low 'bits' bits of a byte (bits in 1..8).
  function automatic logic [7:0] data_mask(input int unsigned bits);
    logic [8:0] m;
    m = (9'd1 << bits) - 9'd1;
    return m[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Byte stream into the UART transmitter (valid/ready handshake).
// Signals: tx_data (byte), tx_valid (source has a byte), tx_ready (sink can take it).
// master = byte source, slave = transmitter.
interface uart_tx_engine_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_edge_det.sv
// Rising-edge detector for a signal already in the clk domain (e.g. a baud square wave).
// Ports: clk, rst_n (async, active-low), sig_i (level in), rise_o (one-cycle pulse on 0->1).
// rise_o is combinational from sig_i against its one-cycle-delayed copy.
module uart_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: serialises bytes LSB-first as start + DATA_BITS data + [parity] + STOP_BITS stop.
// Ports: clk, rst_n, baud_clk_tx (baud square wave), tx_if (byte stream, slave), parity_en/parity_odd,
//        txd (serial out, idles high), tx_idle (no frame pending/in flight), tx_done (end-of-frame pulse).
// Parity bit is generated only when UART_TX_PARITY_EN is defined; otherwise parity inputs are ignored.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_clk_tx,
  uart_tx_engine_if.slave   tx_if,
  input  logic              parity_en,
  input  logic              parity_odd,
  output logic              txd,
  output logic              tx_idle,
  output logic              tx_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [7:0] DMASK     = data_mask(DATA_BITS);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        txd_q, txd_d;
  logic        done_q, done_d;
  logic        idle_q, idle_d;
  logic        bit_tick;

  uart_edge_det u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (baud_clk_tx),
    .rise_o (bit_tick)
  );

`ifdef UART_TX_PARITY_EN
  // Parity mode and bit are frozen at acceptance so mid-frame input changes cannot affect the frame.
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end
`else
  logic unused_parity;
  assign unused_parity = parity_en ^ parity_odd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= UART_IDLE_LEVEL;
      done_q     <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
      idle_q     <= idle_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // tx_ready is high exactly in IDLE, so tx_valid alone means a transfer.
        if (tx_if.tx_valid) begin
          state_d = ST_ALIGN;
          shift_d = tx_if.tx_data & DMASK;
`ifdef UART_TX_PARITY_EN
          par_en_d  = parity_en;
          par_bit_d = (^(tx_if.tx_data & DMASK)) ^ parity_odd;
`endif
        end
      end
      // Hold the line idle until a bit boundary so the start bit is a full period.
      ST_ALIGN: if (bit_tick) state_d = ST_START;
      ST_START: begin
        if (bit_tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      ST_STOP: begin
        if (bit_tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is registered from the next state, so txd moves on the same edge as the FSM.
    case (state_d)
      ST_START:  txd_d = UART_START_LEVEL;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = par_bit_q;
`endif
      default:   txd_d = UART_IDLE_LEVEL;
    endcase

    idle_d = (state_d == ST_IDLE);
  end

  assign tx_if.tx_ready = (state_q == ST_IDLE);
  assign txd            = txd_q;
  assign tx_idle        = idle_q;
  assign tx_done        = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif
  localparam int BIT_CLKS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic baud_gen = 1'b0;
  logic glitch = 1'b0;
  logic baud_run = 1'b1;
  int   bcnt = 0;
  logic parity_en = 1'b0;
  logic parity_odd = 1'b0;
  logic sel = 1'b0;
  int   tests = 0;
  int   fails = 0;

  wire baud_clk_tx = baud_gen | glitch;
  logic txd_a, idle_a, done_a, txd_b, idle_b, done_b;

  uart_tx_engine_if ifa ();
  uart_tx_engine_if ifb ();

  uart_tx_engine #(.DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .baud_clk_tx(baud_clk_tx), .tx_if(ifa.slave),
    .parity_en(parity_en), .parity_odd(parity_odd),
    .txd(txd_a), .tx_idle(idle_a), .tx_done(done_a));

  uart_tx_engine #(.DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .baud_clk_tx(baud_clk_tx), .tx_if(ifb.slave),
    .parity_en(parity_en), .parity_odd(parity_odd),
    .txd(txd_b), .tx_idle(idle_b), .tx_done(done_b));

  wire cur_txd   = sel ? txd_b  : txd_a;
  wire cur_idle  = sel ? idle_b : idle_a;
  wire cur_done  = sel ? done_b : done_a;
  wire cur_ready = sel ? ifb.tx_ready : ifa.tx_ready;

  always #5 clk = ~clk;

  // Baud square wave: 8 clk high, 8 clk low (divisor 16).
  always @(negedge clk) begin
    if (baud_run) begin
      if (bcnt == BIT_CLKS/2 - 1) begin
        bcnt = 0;
        baud_gen = ~baud_gen;
      end else begin
        bcnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte to the selected engine for a single cycle (engine assumed idle).
  task automatic send(input bit s, input logic [7:0] d, input bit pen, input bit podd);
    @(negedge clk);
    parity_en = pen;
    parity_odd = podd;
    if (s) begin ifb.tx_data = d; ifb.tx_valid = 1'b1; end
    else   begin ifa.tx_data = d; ifa.tx_valid = 1'b1; end
    @(negedge clk);
    if (s) ifb.tx_valid = 1'b0; else ifa.tx_valid = 1'b0;
  endtask

  // Reference frame built from the framing rules, then compared cycle by cycle:
  // every bit must hold its level for exactly BIT_CLKS cycles, then tx_done/tx_idle/tx_ready rise together.
  task automatic check_frame(input bit s, input logic [7:0] d, input bit pen, input bit podd,
                             input bit started, input string name);
    bit   bits[$];
    int   dbits, sbits, ones, waitc;
    bit   ok, busy_ok;
    sel   = s;
    dbits = s ? 7 : 8;
    sbits = s ? 2 : 1;
    ones  = 0;
    bits  = {};
    bits.push_back(1'b0);
    for (int i = 0; i < dbits; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (PAR_BUILD && pen) begin
      // Even parity makes the total number of ones even; odd parity makes it odd.
      if (podd) bits.push_back((ones % 2) == 0);
      else      bits.push_back((ones % 2) == 1);
    end
    for (int i = 0; i < sbits; i++) bits.push_back(1'b1);

    if (!started) begin
      waitc = 0;
      while (cur_txd !== 1'b0 && waitc < 3*BIT_CLKS) begin
        @(negedge clk);
        waitc++;
      end
      check({name, "_start_found"}, {31'b0, cur_txd}, 32'd0);
      if (cur_txd !== 1'b0) return;
    end

    for (int b = 0; b < bits.size(); b++) begin
      ok = 1'b1;
      busy_ok = 1'b1;
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (cur_txd !== bits[b]) ok = 1'b0;
        if (cur_ready !== 1'b0 || cur_idle !== 1'b0 || cur_done !== 1'b0) busy_ok = 1'b0;
        // Inputs wiggling while busy must not reach the frame.
        if (s == 1'b0 && ifa.tx_valid == 1'b0) ifa.tx_data = 8'($urandom);
        if (s == 1'b1 && ifb.tx_valid == 1'b0) ifb.tx_data = 8'($urandom);
        if ((s ? ifb.tx_valid : ifa.tx_valid) == 1'b0) begin
          parity_en = 1'($urandom);
          parity_odd = 1'($urandom);
        end
      end
      check($sformatf("%s_bit%0d", name, b), {31'b0, ok}, 32'd1);
      check($sformatf("%s_busy%0d", name, b), {31'b0, busy_ok}, 32'd1);
    end
    @(negedge clk);
    check({name, "_done"},  {31'b0, cur_done},  32'd1);
    check({name, "_idle"},  {31'b0, cur_idle},  32'd1);
    check({name, "_ready"}, {31'b0, cur_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] d;
    bit   pen, podd;
    int   c;
    bit   ok;

    ifa.tx_valid = 1'b0; ifa.tx_data = 8'h00;
    ifb.tx_valid = 1'b0; ifb.tx_data = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd",   {31'b0, txd_a},        32'd1);
    check("rst_ready", {31'b0, ifa.tx_ready}, 32'd1);
    check("rst_idle",  {31'b0, idle_a},       32'd1);
    check("rst_done",  {31'b0, done_a},       32'd0);
    check("rst_txd_b", {31'b0, txd_b},        32'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic frame 0x55
    send(1'b0, 8'h55, 1'b0, 1'b0);
    check_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, "basic");
    @(negedge clk);
    check("basic_done_pulse", {31'b0, done_a}, 32'd0);

    // Back-to-back with tx_valid held high; tx_data changes after acceptance
    pen = 1'($urandom); podd = 1'($urandom);
    @(negedge clk);
    parity_en = pen; parity_odd = podd;
    ifa.tx_data = 8'hA3; ifa.tx_valid = 1'b1;
    @(negedge clk);
    ifa.tx_data = 8'h0F;
    check_frame(1'b0, 8'hA3, pen, podd, 1'b0, "b2b_a");
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        check("b2b_ready_drop", {31'b0, ifa.tx_ready}, 32'd0);
        ifa.tx_valid = 1'b0;
      end
    end while (txd_a !== 1'b0 && c < 3*BIT_CLKS);
    check("b2b_gap_max", {31'b0, c <= BIT_CLKS}, 32'd1);
    check("b2b_gap_min", {31'b0, c >= 2}, 32'd1);
    check_frame(1'b0, 8'h0F, pen, podd, 1'b1, "b2b_b");

    // Parity 0x07, even then odd
    send(1'b0, 8'h07, 1'b1, 1'b0);
    check_frame(1'b0, 8'h07, 1'b1, 1'b0, 1'b0, "par_even");
    send(1'b0, 8'h07, 1'b1, 1'b1);
    check_frame(1'b0, 8'h07, 1'b1, 1'b1, 1'b0, "par_odd");

    // Randomized frames on the 8N1 engine
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom); pen = 1'($urandom); podd = 1'($urandom);
      send(1'b0, d, pen, podd);
      check_frame(1'b0, d, pen, podd, 1'b0, $sformatf("rnd%0d", i));
    end

    // 7 data bits, 2 stop bits
    send(1'b1, 8'h7F, 1'b0, 1'b0);
    check_frame(1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, "b7f");
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom); pen = 1'($urandom); podd = 1'($urandom);
      send(1'b1, d, pen, podd);
      check_frame(1'b1, d, pen, podd, 1'b0, $sformatf("brnd%0d", i));
    end

    // Spurious ticks while idle, baud otherwise stuck low
    sel = 1'b0;
    @(posedge clk);
    while (baud_gen) @(posedge clk);
    baud_run = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2 glitch = 1'b1;
      @(posedge clk); #2 glitch = 1'b0;
      if (txd_a !== 1'b1 || idle_a !== 1'b1 || ifa.tx_ready !== 1'b1) ok = 1'b0;
      @(posedge clk); #2;
      if (txd_a !== 1'b1 || idle_a !== 1'b1 || ifa.tx_ready !== 1'b1) ok = 1'b0;
    end
    check("idle_tick_ignored", {31'b0, ok}, 32'd1);
    baud_run = 1'b1;

    // Reset during data bit 3 of 0xF7 (bit 3 is 0)
    send(1'b0, 8'hF7, 1'b0, 1'b0);
    c = 0;
    while (txd_a !== 1'b0 && c < 3*BIT_CLKS) begin @(negedge clk); c++; end
    repeat (4*BIT_CLKS + BIT_CLKS/2) @(negedge clk);
    check("pre_rst_bit3", {31'b0, txd_a}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_txd",   {31'b0, txd_a},        32'd1);
    check("mid_rst_ready", {31'b0, ifa.tx_ready}, 32'd1);
    check("mid_rst_idle",  {31'b0, idle_a},       32'd1);
    check("mid_rst_done",  {31'b0, done_a},       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    d = 8'($urandom);
    send(1'b0, d, 1'b0, 1'b0);
    check_frame(1'b0, d, 1'b0, 1'b0, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
